access_control_param: RTL and testbench

ACCESS_CONTROL_PARAM -- requirements
Module: access_control_param

---
 rtl/access_control_param.sv | 157 +++++++++++++++
 tb/tb_access_control_param.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/access_control_param.sv
// Password-gated access controller: user ID + password check against external memory,
// optional password change with confirmation, and timed lockout after repeated failures.
//
// state   | meaning
// IDLE    | waiting for a user-ID word (bit DATA_W-1 requests a password change)
// WAIT_PW | waiting for the password word
// READ    | holding address for RD_LAT clocks, then capturing mem_in
// CHECK   | comparing the entered password with the stored one
// GRANT   | user logged in; next strobe logs out
// NEW_PW  | waiting for the new password
// CONFIRM | waiting for the confirmation of the new password
// WRITE   | one-cycle memory write of the new password
// LOCKOUT | too many consecutive failures; strobes ignored until timer expires
module access_control_param #(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 8,
  parameter int MAX_FAIL    = 3,
  parameter int LOCK_CYCLES = 1024,
  parameter int RD_LAT      = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_in_load,
  input  logic [DATA_W-1:0] mem_in,
  output logic              access_grant,
  output logic              locked,
  output logic              busy,
  output logic [3:0]        fail_count,
  output logic [ADDR_W-1:0] address,
  output logic              wren,
  output logic [DATA_W-1:0] data_out
);

  localparam int RC_W = (RD_LAT > 1) ? $clog2(RD_LAT + 1) : 1;
  localparam int LC_W = (LOCK_CYCLES > 1) ? $clog2(LOCK_CYCLES) : 1;

  typedef enum logic [3:0] {
    IDLE, WAIT_PW, READ, CHECK, GRANT, NEW_PW, CONFIRM, WRITE, LOCKOUT
  } state_t;

  state_t            state;
  logic              change_flag;
  logic [DATA_W-1:0] user_pw;
  logic [DATA_W-1:0] mem_pw;
  logic [DATA_W-1:0] new_pw;
  logic [RC_W-1:0]   rd_cnt;
  logic [LC_W-1:0]   lock_cnt;
  logic [3:0]        fail_inc;
  logic              pw_match;

  // Saturating increment keeps fail_count from ever exceeding MAX_FAIL.
  assign fail_inc = (fail_count >= 4'(MAX_FAIL)) ? fail_count : fail_count + 4'd1;
  assign pw_match = (user_pw == mem_pw);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      change_flag  <= 1'b0;
      user_pw      <= '0;
      mem_pw       <= '0;
      new_pw       <= '0;
      rd_cnt       <= '0;
      lock_cnt     <= '0;
      access_grant <= 1'b0;
      locked       <= 1'b0;
      busy         <= 1'b0;
      fail_count   <= '0;
      address      <= '0;
      wren         <= 1'b0;
      data_out     <= '0;
    end else begin
      wren <= 1'b0;
      case (state)
        IDLE: if (data_in_load) begin
          change_flag <= data_in[DATA_W-1];
          address     <= data_in[ADDR_W-1:0];
          busy        <= 1'b1;
          state       <= WAIT_PW;
        end
        WAIT_PW: if (data_in_load) begin
          user_pw <= data_in;
          rd_cnt  <= '0;
          state   <= READ;
        end
        READ: begin
          if (rd_cnt == RC_W'(RD_LAT - 1)) begin
            mem_pw <= mem_in;
            state  <= CHECK;
          end else begin
            rd_cnt <= rd_cnt + 1'b1;
          end
        end
        CHECK: begin
          if (pw_match) begin
            fail_count <= '0;
            if (change_flag) begin
              state <= NEW_PW;
            end else begin
              access_grant <= 1'b1;
              state        <= GRANT;
            end
          end else begin
            fail_count <= fail_inc;
            if (fail_inc == 4'(MAX_FAIL)) begin
              locked   <= 1'b1;
              lock_cnt <= LC_W'(LOCK_CYCLES - 1);
              state    <= LOCKOUT;
            end else begin
              state <= WAIT_PW;
            end
          end
        end
        GRANT: if (data_in_load) begin
          access_grant <= 1'b0;
          fail_count   <= '0;
          busy         <= 1'b0;
          state        <= IDLE;
        end
        NEW_PW: if (data_in_load) begin
          new_pw <= data_in;
          state  <= CONFIRM;
        end
        CONFIRM: if (data_in_load) begin
          if (data_in == new_pw) begin
            wren     <= 1'b1;
            data_out <= new_pw;
            state    <= WRITE;
          end else begin
            new_pw <= '0;
            state  <= NEW_PW;
          end
        end
        WRITE: begin
          fail_count <= '0;
          busy       <= 1'b0;
          state      <= IDLE;
        end
        LOCKOUT: begin
          if (lock_cnt == '0) begin
            locked     <= 1'b0;
            fail_count <= '0;
            busy       <= 1'b0;
            state      <= IDLE;
          end else begin
            lock_cnt <= lock_cnt - 1'b1;
          end
        end
        default: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_access_control_param.sv
// Bench for access_control_param: directed login/lockout/change/reset scenarios and
// random strobes, checked every cycle against a session-level reference model.
module tb_access_control_param;

  localparam int DW = 16;
  localparam int AW = 8;
  localparam int MAX_FAIL = 3;
  localparam int LOCK_CYCLES = 20;
  localparam int RD_LAT = 2;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic          data_in_load = 1'b0;
  logic [DW-1:0] mem_in;
  logic          access_grant, locked, busy, wren;
  logic [3:0]    fail_count;
  logic [AW-1:0] address;
  logic [DW-1:0] data_out;

  int checks = 0;
  int errors = 0;
  int wren_seen = 0;
  bit cmp_en = 1'b0;

  logic [DW-1:0] mem [0:255];
  assign mem_in = mem[address];

  access_control_param #(
    .DATA_W(DW), .ADDR_W(AW), .MAX_FAIL(MAX_FAIL),
    .LOCK_CYCLES(LOCK_CYCLES), .RD_LAT(RD_LAT)
  ) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .data_in_load(data_in_load),
    .mem_in(mem_in), .access_grant(access_grant), .locked(locked), .busy(busy),
    .fail_count(fail_count), .address(address), .wren(wren), .data_out(data_out)
  );

  always #5 clk = ~clk;

  // Reference model: tracks which word the user is expected to send next.
  localparam int M_ID = 0, M_PW = 1, M_VERIFY = 2, M_IN = 3, M_NEW = 4,
                 M_CONF = 5, M_WR = 6, M_LOCK = 7;
  int            mode, verify_left, lock_left;
  logic          m_flag;
  logic [DW-1:0] m_user_pw, m_new_pw, m_dout;
  logic [AW-1:0] m_addr;
  logic [3:0]    m_fail;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mode = M_ID; verify_left = 0; lock_left = 0;
      m_flag = 0; m_user_pw = '0; m_new_pw = '0; m_dout = '0; m_addr = '0; m_fail = '0;
      for (int i = 0; i < 256; i++) mem[i] = 16'(i * 37 + 1);
      mem[0] = 16'h0000;
      mem[3] = 16'h4321;
      mem[5] = 16'h1234;
    end else begin
      case (mode)
        M_ID: if (data_in_load) begin
          m_flag = data_in[DW-1]; m_addr = data_in[AW-1:0]; mode = M_PW;
        end
        M_PW: if (data_in_load) begin
          m_user_pw = data_in; verify_left = RD_LAT + 1; mode = M_VERIFY;
        end
        M_VERIFY: begin
          verify_left--;
          if (verify_left == 0) begin
            if (m_user_pw == mem[m_addr]) begin
              m_fail = 0;
              mode = m_flag ? M_NEW : M_IN;
            end else begin
              if (m_fail < MAX_FAIL) m_fail++;
              if (m_fail == MAX_FAIL) begin mode = M_LOCK; lock_left = LOCK_CYCLES; end
              else mode = M_PW;
            end
          end
        end
        M_IN: if (data_in_load) begin mode = M_ID; m_fail = 0; end
        M_NEW: if (data_in_load) begin m_new_pw = data_in; mode = M_CONF; end
        M_CONF: if (data_in_load) begin
          if (data_in == m_new_pw) begin m_dout = m_new_pw; mode = M_WR; end
          else mode = M_NEW;
        end
        M_WR: begin mem[m_addr] = m_dout; mode = M_ID; m_fail = 0; end
        M_LOCK: begin
          lock_left--;
          if (lock_left == 0) begin mode = M_ID; m_fail = 0; end
        end
        default: mode = M_ID;
      endcase
    end
  end

  always @(negedge clk) begin
    if (wren === 1'b1) wren_seen++;
    if (cmp_en) begin
      checks++;
      if (access_grant !== (mode == M_IN) || locked !== (mode == M_LOCK) ||
          busy !== (mode != M_ID) || fail_count !== m_fail || address !== m_addr ||
          wren !== (mode == M_WR) || data_out !== m_dout) begin
        errors++;
        $display("FAIL cycle_cmp t=%0t got grant=%b locked=%b busy=%b fail=%0d addr=%h wren=%b dout=%h expected grant=%b locked=%b busy=%b fail=%0d addr=%h wren=%b dout=%h",
                 $time, access_grant, locked, busy, fail_count, address, wren, data_out,
                 mode == M_IN, mode == M_LOCK, mode != M_ID, m_fail, m_addr, mode == M_WR, m_dout);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_grant"}, 32'(access_grant), 0);
    chk({tag, "_locked"}, 32'(locked), 0);
    chk({tag, "_busy"}, 32'(busy), 0);
    chk({tag, "_fail"}, 32'(fail_count), 0);
    chk({tag, "_addr"}, 32'(address), 0);
    chk({tag, "_wren"}, 32'(wren), 0);
    chk({tag, "_dout"}, 32'(data_out), 0);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic load(input logic [DW-1:0] w);
    data_in = w;
    data_in_load = 1'b1;
    @(negedge clk);
    data_in_load = 1'b0;
    data_in = 16'($urandom);
  endtask

  task automatic wrong_pw(input logic [DW-1:0] w, input int exp_fail, input string name);
    load(w);
    tick(RD_LAT + 1);
    chk(name, 32'(fail_count), 32'(exp_fail));
  endtask

  task automatic login_ok(input string name);
    int lat;
    load(16'h0005);
    load(16'h1234);
    lat = 0;
    while (access_grant !== 1'b1 && lat < RD_LAT + 3) begin
      @(negedge clk);
      lat++;
    end
    chk({name, "_grant"}, 32'(access_grant), 1);
    load(16'h0000);
    chk({name, "_logout_grant"}, 32'(access_grant), 0);
    chk({name, "_logout_busy"}, 32'(busy), 0);
  endtask

  initial begin
    int cnt, w0;
    logic [DW-1:0] w, last_w;
    logic [AW-1:0] id;
    logic flag;

    tick(3);
    chk_reset("reset");
    rst = 1'b1;
    cmp_en = 1'b1;
    tick(1);

    // Good login and logout
    login_ok("login");

    // Two failures, then success: fail_count 1, 2, then 0 with grant
    load(16'h0005);
    wrong_pw(16'h1111, 1, "retry_fail1");
    wrong_pw(16'h2222, 2, "retry_fail2");
    load(16'h1234);
    tick(RD_LAT + 1);
    chk("retry_fail_clear", 32'(fail_count), 0);
    chk("retry_grant", 32'(access_grant), 1);
    chk("retry_no_lock", 32'(locked), 0);
    load(16'h0000);

    // Lockout with strobes during lockout
    load(16'h0005);
    wrong_pw(16'h0001, 1, "lock_fail1");
    wrong_pw(16'h0002, 2, "lock_fail2");
    wrong_pw(16'h0003, 3, "lock_fail3");
    chk("lock_set", 32'(locked), 1);
    cnt = 0;
    while (locked === 1'b1 && cnt < LOCK_CYCLES + 5) begin
      cnt++;
      if (cnt % 4 == 0) load(16'h0005); else tick(1);
    end
    chk("lock_duration", 32'(cnt), 32'(LOCK_CYCLES));
    chk("lock_fail_clear", 32'(fail_count), 0);
    chk("lock_idle", 32'(busy), 0);

    // Password change for user 3
    w0 = wren_seen;
    load(16'h8003);
    load(16'h4321);
    tick(RD_LAT + 1);
    chk("chg_no_grant", 32'(access_grant), 0);
    chk("chg_busy", 32'(busy), 1);
    load(16'hBEEF);
    load(16'hBEEF);
    chk("chg_wren", 32'(wren), 1);
    chk("chg_addr", 32'(address), 32'h03);
    chk("chg_dout", 32'(data_out), 32'hBEEF);
    tick(1);
    chk("chg_wren_low", 32'(wren), 0);
    chk("chg_single_pulse", 32'(wren_seen - w0), 1);

    // Confirm mismatch, then matching pair (password for user 3 is now BEEF)
    w0 = wren_seen;
    load(16'h8003);
    load(16'hBEEF);
    tick(RD_LAT + 1);
    load(16'hBEEF);
    load(16'hBEEE);
    chk("cfm_mismatch_nowren", 32'(wren_seen - w0), 0);
    chk("cfm_mismatch_busy", 32'(busy), 1);
    load(16'h5A5A);
    load(16'h5A5A);
    chk("cfm_match_wren", 32'(wren), 1);
    chk("cfm_match_dout", 32'(data_out), 32'h5A5A);
    tick(1);

    // Reset during READ
    load(16'h0005);
    load(16'h1234);
    #2 rst = 1'b0;
    #1 chk_reset("rst_read");
    @(negedge clk);
    rst = 1'b1;
    tick(1);
    login_ok("after_rst_read");

    // Reset during LOCKOUT
    load(16'h0005);
    wrong_pw(16'h0009, 1, "rl_fail1");
    wrong_pw(16'h0009, 2, "rl_fail2");
    wrong_pw(16'h0009, 3, "rl_fail3");
    tick(3);
    chk("rl_locked", 32'(locked), 1);
    #2 rst = 1'b0;
    #1 chk_reset("rst_lock");
    @(negedge clk);
    rst = 1'b1;
    tick(1);
    login_ok("after_rst_lock");

    // Random strobes, checked cycle by cycle against the model
    last_w = 16'h0000;
    for (int i = 0; i < 4000; i++) begin
      if ($urandom_range(0, 2) == 0) begin
        case ($urandom_range(0, 4))
          0: id = 8'h00;
          1: id = 8'h01;
          2: id = 8'h02;
          3: id = 8'h03;
          default: id = 8'h05;
        endcase
        flag = 1'($urandom_range(0, 1));
        case ($urandom_range(0, 5))
          0: w = {flag, 7'b0, id};
          1, 2: w = mem[id];
          3: w = last_w;
          4: w = last_w ^ 16'h0001;
          default: w = 16'($urandom);
        endcase
        last_w = w;
        load(w);
      end else begin
        tick(1);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
